// File: rtl/pipe_add_sub_if.sv
// Handshake bundle for pipe_add_sub: operand/valid/ready on the input side,
// result/flags/valid/ready on the output side.
interface pipe_add_sub_if #(
   parameter int DATAWIDTH = 8
);
   logic [DATAWIDTH-1:0] a;
   logic [DATAWIDTH-1:0] b;
   logic                 sub;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATAWIDTH-1:0] out;
   logic                 cout;
   logic                 ovf;
   logic                 out_valid;
   logic                 out_ready;

   // Both sides: a transfer happens on a rising clock edge where valid and ready
   // are both high; a producer holds its payload steady until that edge.
   modport slave (
      input  a, b, sub, in_valid, out_ready,
      output in_ready, out, cout, ovf, out_valid
   );

   modport master (
      output a, b, sub, in_valid, out_ready,
      input  in_ready, out, cout, ovf, out_valid
   );
endinterface

// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor: one CW-bit chunk resolved per stage, carry rippling
// through the stage registers, whole-pipe stall when the result is not taken.
module pipe_add_sub #(
   parameter int DATAWIDTH = 8,
   parameter int STAGES    = 2
) (
   input  logic          Clk,
   input  logic          Rst,
   pipe_add_sub_if.slave bus
);
   localparam int CW  = DATAWIDTH / STAGES;
   localparam int MSB = DATAWIDTH - 1;

   // Stage register k holds the op after chunk k is resolved; k = STAGES-1 is the output.
   logic [DATAWIDTH-1:0] aa_q  [STAGES];
   logic [DATAWIDTH-1:0] bb_q  [STAGES];
   logic [DATAWIDTH-1:0] sum_q [STAGES];
   logic                 cy_q  [STAGES];
   logic [STAGES-1:0]    vld_q;
   logic                 ovf_q;

   logic [DATAWIDTH-1:0] aa_d   [STAGES];
   logic [DATAWIDTH-1:0] bb_d   [STAGES];
   logic [DATAWIDTH-1:0] sum_d  [STAGES];
   logic                 cy_d   [STAGES];
   logic [STAGES-1:0]    vld_d;
   logic                 ovf_d;
   logic [DATAWIDTH-1:0] sum_in [STAGES];
   logic                 cin    [STAGES];
   logic [CW:0]          chunk  [STAGES];

   logic stall;
   logic advance;

   assign stall        = vld_q[STAGES-1] & ~bus.out_ready;
   assign advance      = ~stall;
   assign bus.in_ready = Rst & ~stall;

   // Subtraction is folded in at entry: b is inverted and the +1 rides in as carry-in.
   always_comb begin : stage_inputs
      vld_d     = '0;
      aa_d[0]   = bus.a;
      bb_d[0]   = bus.sub ? ~bus.b : bus.b;
      sum_in[0] = '0;
      cin[0]    = bus.sub;
      vld_d[0]  = bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
         aa_d[k]   = aa_q[k-1];
         bb_d[k]   = bb_q[k-1];
         sum_in[k] = sum_q[k-1];
         cin[k]    = cy_q[k-1];
         vld_d[k]  = vld_q[k-1];
      end
   end

   always_comb begin : chunk_adders
      for (int k = 0; k < STAGES; k++) begin
         chunk[k] = {1'b0, aa_d[k][k*CW +: CW]}
                  + {1'b0, bb_d[k][k*CW +: CW]}
                  + {{CW{1'b0}}, cin[k]};
         sum_d[k]             = sum_in[k];
         sum_d[k][k*CW +: CW] = chunk[k][CW-1:0];
         cy_d[k]              = chunk[k][CW];
      end
      ovf_d = (aa_d[STAGES-1][MSB] == bb_d[STAGES-1][MSB])
            & (sum_d[STAGES-1][MSB] != aa_d[STAGES-1][MSB]);
   end

   // Payload registers only load on a valid op, so the outputs hold across bubbles.
   always_ff @(posedge Clk) begin : stage_regs
      if (!Rst) begin
         vld_q <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            aa_q[k]  <= '0;
            bb_q[k]  <= '0;
            sum_q[k] <= '0;
            cy_q[k]  <= 1'b0;
         end
      end else if (advance) begin
         vld_q <= vld_d;
         for (int k = 0; k < STAGES; k++) begin
            if (vld_d[k]) begin
               aa_q[k]  <= aa_d[k];
               bb_q[k]  <= bb_d[k];
               sum_q[k] <= sum_d[k];
               cy_q[k]  <= cy_d[k];
            end
         end
         if (vld_d[STAGES-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign bus.out       = sum_q[STAGES-1];
   assign bus.cout      = cy_q[STAGES-1];
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = vld_q[STAGES-1];
endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed bench for pipe_add_sub: 8-bit/2-stage main instance plus 16-bit
// 4-stage and 1-stage instances for latency, chunk-carry and stall behaviour.
module tb_pipe_add_sub;
   logic Clk = 1'b0;
   logic Rst = 1'b0;

   always #5 Clk = ~Clk;

   pipe_add_sub_if #(.DATAWIDTH(8))  b8 ();
   pipe_add_sub_if #(.DATAWIDTH(16)) b4 ();
   pipe_add_sub_if #(.DATAWIDTH(16)) b1 ();

   pipe_add_sub #(.DATAWIDTH(8),  .STAGES(2)) dut_s2 (.Clk(Clk), .Rst(Rst), .bus(b8));
   pipe_add_sub #(.DATAWIDTH(16), .STAGES(4)) dut_s4 (.Clk(Clk), .Rst(Rst), .bus(b4));
   pipe_add_sub #(.DATAWIDTH(16), .STAGES(1)) dut_s1 (.Clk(Clk), .Rst(Rst), .bus(b1));

   int n_checks = 0;
   int n_fail   = 0;
   logic [17:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic vld);
      b8.a = a; b8.b = b; b8.sub = sub; b8.in_valid = vld;
   endtask

   task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic vld);
      b4.a = a; b4.b = b; b4.sub = sub; b4.in_valid = vld;
      b1.a = a; b1.b = b; b1.sub = sub; b1.in_valid = vld;
   endtask

   task automatic check8(input string tag, input logic [7:0] out, input logic cout, input logic ovf);
      check({tag, "_valid"}, b8.out_valid, 1);
      check({tag, "_out"},   b8.out, out);
      check({tag, "_cout"},  b8.cout, cout);
      check({tag, "_ovf"},   b8.ovf, ovf);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] va [6];
      logic [15:0] vb [6];
      logic        vs [6];
      logic [17:0] ve [6];
      logic [15:0] sa [5];
      logic [15:0] sb [5];
      logic        ss [5];
      logic [17:0] se [5];
      logic [17:0] exp;
      int sent, got, idx;
      logic fire_in;

      drive8(8'h00, 8'h00, 1'b0, 1'b0);
      drive16(16'h0, 16'h0, 1'b0, 1'b0);
      b8.out_ready = 1'b1; b4.out_ready = 1'b1; b1.out_ready = 1'b1;

      // Reset held two cycles with a valid op presented
      Rst = 1'b0;
      drive8(8'hAA, 8'h55, 1'b0, 1'b1);
      tick(); tick();
      check("rst_out_valid", b8.out_valid, 0);
      check("rst_out", b8.out, 0);
      check("rst_cout", b8.cout, 0);
      check("rst_ovf", b8.ovf, 0);
      check("rst_in_ready", b8.in_ready, 0);
      check("rst_s4_out_valid", b4.out_valid, 0);
      check("rst_s1_out_valid", b1.out_valid, 0);
      Rst = 1'b1;
      drive8(8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      check("rel_in_ready", b8.in_ready, 1);

      // Directed add/sub with overflow and carry corners, back to back
      drive8(8'h7F, 8'h01, 1'b0, 1'b1);
      tick();
      check("lat_not_one", b8.out_valid, 0);
      drive8(8'hFF, 8'h01, 1'b0, 1'b1);
      tick();
      check8("add_7f_01", 8'h80, 1'b0, 1'b1);
      drive8(8'h05, 8'h07, 1'b1, 1'b1);
      tick();
      check8("add_ff_01", 8'h00, 1'b1, 1'b0);
      drive8(8'h80, 8'h01, 1'b1, 1'b1);
      tick();
      check8("sub_05_07", 8'hFE, 1'b0, 1'b0);
      drive8(8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      check8("sub_80_01", 8'h7F, 1'b1, 1'b1);
      tick();
      check("bubble_valid", b8.out_valid, 0);
      check("bubble_hold_out", b8.out, 8'h7F);

      // Stream of 8 ops with out_ready low for cycles 3-5
      for (int i = 0; i < 8; i++) exp_q.push_back(18'(i * 8'h11));
      sent = 0; got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         b8.out_ready = !(c >= 3 && c <= 5);
         if (sent < 8) drive8(8'(sent), 8'(sent * 16), 1'b0, 1'b1);
         else          drive8(8'h00, 8'h00, 1'b0, 1'b0);
         #1;
         check("stream_in_ready", b8.in_ready, (c >= 3 && c <= 5) ? 0 : 1);
         fire_in = b8.in_valid && b8.in_ready;
         if (b8.out_valid && b8.out_ready && exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("stream_out", b8.out, exp[7:0]);
            got++;
         end
         tick();
         if (fire_in) sent++;
      end
      check("stream_count", got, 8);
      check("stream_no_dup", b8.out_valid, 0);
      exp_q.delete();

      // Reset with two ops in flight
      b8.out_ready = 1'b0;
      drive8(8'h11, 8'h22, 1'b0, 1'b1);
      tick();
      drive8(8'h33, 8'h44, 1'b0, 1'b1);
      tick();
      check("flight_valid", b8.out_valid, 1);
      Rst = 1'b0;
      drive8(8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      check("flush_valid", b8.out_valid, 0);
      check("flush_out", b8.out, 0);
      Rst = 1'b1;
      b8.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("flush_gone", b8.out_valid, 0);
      end
      drive8(8'h12, 8'h34, 1'b0, 1'b1);
      tick();
      drive8(8'h00, 8'h00, 1'b0, 1'b0);
      check("fresh_lat", b8.out_valid, 0);
      tick();
      check8("fresh_op", 8'h46, 1'b0, 1'b0);

      // 16-bit, STAGES=4 and STAGES=1: latency and carry through every chunk
      va = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000, 16'h1234, 16'hF0F0};
      vb = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h4321, 16'h0F0F};
      vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      ve = '{{2'b10, 16'h0000}, {2'b01, 16'h8000}, {2'b00, 16'hFFFF},
             {2'b11, 16'h7FFF}, {2'b00, 16'h5555}, {2'b10, 16'hE1E1}};
      for (int c = 0; c < 12; c++) begin
         if (c < 6) drive16(va[c], vb[c], vs[c], 1'b1);
         else       drive16(16'h0, 16'h0, 1'b0, 1'b0);
         tick();
         check("s4_valid", b4.out_valid, (c >= 3 && c < 9) ? 1 : 0);
         if (c >= 3 && c < 9) check("s4_res", {b4.cout, b4.ovf, b4.out}, ve[c-3]);
         check("s1_valid", b1.out_valid, (c < 6) ? 1 : 0);
         if (c < 6) check("s1_res", {b1.cout, b1.ovf, b1.out}, ve[c]);
      end

      // STAGES=4 with bubbles and irregular backpressure
      sa = '{16'h0001, 16'h00FF, 16'hFFFF, 16'h4000, 16'h1000};
      sb = '{16'h0002, 16'h0001, 16'hFFFF, 16'h4000, 16'h2000};
      ss = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      se = '{{2'b00, 16'h0003}, {2'b00, 16'h0100}, {2'b10, 16'hFFFE},
             {2'b01, 16'h8000}, {2'b00, 16'hF000}};
      idx = 0; got = 0;
      for (int c = 0; c < 60 && got < 5; c++) begin
         b4.out_ready = (c % 4 != 2) && !(c >= 5 && c <= 7);
         if (idx < 5 && (c % 3 != 1)) drive16(sa[idx], sb[idx], ss[idx], 1'b1);
         else                         drive16(16'h0, 16'h0, 1'b0, 1'b0);
         #1;
         fire_in = b4.in_valid && b4.in_ready;
         if (fire_in) exp_q.push_back(se[idx]);
         if (b4.out_valid && b4.out_ready && exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("s4_stall_res", {b4.cout, b4.ovf, b4.out}, exp);
            got++;
         end
         tick();
         if (fire_in) idx++;
      end
      check("s4_stall_count", got, 5);
      check("s4_stall_drained", b4.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
